lcd_bus_writer: RTL and testbench

- Downstream stage of the character/command sequencer. Accepts {rs, data} byte writes over a valid/ready handshake, buffers them in a small FIFO, and drives the HD44780-style parallel LCD bus.
- Generates the lcd_e strobe with the required setup, pulse-width, hold and per-instruction execution delays.
- Replaces the sequencer's free-running divided clock on lcd_e. The sequencer only pushes bytes; all bus timing is owned here.

---
 rtl/lcd_bus_writer.sv | 166 ++++++++++++++++
 tb/tb_lcd_bus_writer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_bus_writer.sv
// HD44780-style parallel LCD bus writer: buffers {rs,data} writes in a small FIFO
// and owns all lcd_e timing (power-up wait, setup, pulse, hold, execution delay).
module lcd_bus_writer #(
  parameter int unsigned T_POWERUP   = 750000,
  parameter int unsigned T_SETUP     = 2,
  parameter int unsigned T_PW        = 25,
  parameter int unsigned T_HOLD      = 2,
  parameter int unsigned T_EXEC      = 2000,
  parameter int unsigned T_EXEC_LONG = 80000,
  parameter int unsigned CW          = 20,
  parameter int unsigned DEPTH_LOG2  = 2
) (
  input  logic       in_Clk,
  input  logic       rst_n,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic       wr_rs,
  input  logic [7:0] wr_data,
  output logic       busy,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic [7:0] lcd_data
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned PW    = DEPTH_LOG2 + 1;

  localparam logic [CW-1:0] POWERUP_LAST = CW'(T_POWERUP - 1);
  localparam logic [CW-1:0] SETUP_LAST   = CW'(T_SETUP - 1);
  localparam logic [CW-1:0] PULSE_LAST   = CW'(T_PW - 1);
  localparam logic [CW-1:0] HOLD_LAST    = CW'(T_HOLD - 1);
  localparam logic [CW-1:0] EXEC_LAST    = CW'(T_EXEC - 1);
  localparam logic [CW-1:0] LONG_LAST    = CW'(T_EXEC_LONG - 1);
  localparam logic [PW-1:0] FILL_FULL    = PW'(DEPTH);

  typedef enum logic [2:0] {
    ST_POWERUP,
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_HOLD,
    ST_EXEC
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          long_q;

  logic [PW-1:0] wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
  logic [PW-1:0] fill, fill_n;
  logic [8:0]    mem [DEPTH];
  logic [8:0]    head;
  logic          push, pop, fifo_empty;

  // Full/empty come from the pointer difference; the extra pointer bit
  // distinguishes a full FIFO from an empty one.
  assign fill       = wr_ptr - rd_ptr;
  assign fifo_empty = (fill == '0);
  assign head       = mem[rd_ptr[DEPTH_LOG2-1:0]];

  // wr_ready is the registered not-full flag, so a pop on a full FIFO never
  // opens the door for a push in the same cycle.
  assign push     = wr_valid && wr_ready;
  assign wr_ptr_n = wr_ptr + PW'(push);
  assign rd_ptr_n = rd_ptr + PW'(pop);
  assign fill_n   = wr_ptr_n - rd_ptr_n;

  assign lcd_rw = 1'b0;

  always_ff @(posedge in_Clk) begin
    if (push) begin
      mem[wr_ptr[DEPTH_LOG2-1:0]] <= {wr_rs, wr_data};
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    pop     = 1'b0;
    case (state)
      ST_POWERUP: begin
        if (cnt == POWERUP_LAST) begin
          state_n = ST_IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_n = ST_SETUP;
          cnt_n   = '0;
        end
      end
      ST_SETUP: begin
        if (cnt == SETUP_LAST) begin
          state_n = ST_PULSE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      ST_PULSE: begin
        if (cnt == PULSE_LAST) begin
          state_n = ST_HOLD;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      ST_HOLD: begin
        if (cnt == HOLD_LAST) begin
          state_n = ST_EXEC;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      ST_EXEC: begin
        if (cnt == (long_q ? LONG_LAST : EXEC_LAST)) begin
          state_n = ST_IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: begin
        state_n = ST_POWERUP;
        cnt_n   = '0;
      end
    endcase
  end

  // Outputs are registered from next-state values so lcd_e, wr_ready and busy
  // line up with the state they describe without any combinational decode.
  always_ff @(posedge in_Clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_POWERUP;
      cnt      <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      long_q   <= 1'b0;
      lcd_rs   <= 1'b0;
      lcd_data <= '0;
      lcd_e    <= 1'b0;
      wr_ready <= 1'b0;
      busy     <= 1'b1;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      wr_ptr   <= wr_ptr_n;
      rd_ptr   <= rd_ptr_n;
      lcd_e    <= (state_n == ST_PULSE);
      wr_ready <= (fill_n != FILL_FULL);
      busy     <= !((state_n == ST_IDLE) && (fill_n == '0));
      if (pop) begin
        lcd_rs   <= head[8];
        lcd_data <= head[7:0];
        long_q   <= !head[8] && (head[7:0] inside {8'h01, 8'h02, 8'h03});
      end
    end
  end

endmodule

// File: tb/tb_lcd_bus_writer.sv
// Scoreboard bench for lcd_bus_writer: the driver queues each accepted byte with its
// accept edge; a monitor checks every lcd_e pulse against timing predicted from the bus rules.
module tb_lcd_bus_writer;

  localparam int unsigned T_POWERUP   = 10;
  localparam int unsigned T_SETUP     = 2;
  localparam int unsigned T_PW        = 3;
  localparam int unsigned T_HOLD      = 1;
  localparam int unsigned T_EXEC      = 5;
  localparam int unsigned T_EXEC_LONG = 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic       wr_rs = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       busy, lcd_rs, lcd_rw, lcd_e;
  logic [7:0] lcd_data;

  always #5 clk = ~clk;

  lcd_bus_writer #(
    .T_POWERUP(T_POWERUP),
    .T_SETUP(T_SETUP),
    .T_PW(T_PW),
    .T_HOLD(T_HOLD),
    .T_EXEC(T_EXEC),
    .T_EXEC_LONG(T_EXEC_LONG),
    .CW(20),
    .DEPTH_LOG2(2)
  ) dut (
    .in_Clk(clk),
    .rst_n(rst_n),
    .wr_valid(wr_valid),
    .wr_ready(wr_ready),
    .wr_rs(wr_rs),
    .wr_data(wr_data),
    .busy(busy),
    .lcd_rs(lcd_rs),
    .lcd_rw(lcd_rw),
    .lcd_e(lcd_e),
    .lcd_data(lcd_data)
  );

  typedef struct {
    logic       rs;
    logic [7:0] data;
    int         acc;
  } item_t;

  item_t exp_q[$];
  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int rel_cyc = 0;
  int ready_edge = 0;
  int last_rise = 0;
  int rise_count = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int exec_len(input logic rs, input logic [7:0] d);
    return (!rs && d >= 8'h01 && d <= 8'h03) ? int'(T_EXEC_LONG) : int'(T_EXEC);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic bound_expired(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
  endtask

  // Monitor: a byte popped while the bus is free rises T_SETUP after the pop;
  // the bus is free again one cycle after pulse + hold + execution delay.
  logic  e_prev = 1'b0;
  int    pw_cnt = 0;
  item_t m_it;
  int    m_exp;

  always @(negedge clk) begin
    if (!rst_n) begin
      e_prev = 1'b0;
      pw_cnt = 0;
    end else begin
      if (lcd_e && !e_prev) begin
        if (exp_q.size() == 0) begin
          bound_expired("unexpected_lcd_e");
        end else begin
          m_it  = exp_q.pop_front();
          m_exp = ((ready_edge > m_it.acc + 1) ? ready_edge : m_it.acc + 1) + int'(T_SETUP);
          chk("rise_cycle", cyc, m_exp);
          chk("lcd_data", int'(lcd_data), int'(m_it.data));
          chk("lcd_rs", int'(lcd_rs), int'(m_it.rs));
          chk("lcd_rw", int'(lcd_rw), 0);
          ready_edge = cyc + int'(T_PW) + int'(T_HOLD) + exec_len(m_it.rs, m_it.data) + 1;
          last_rise  = cyc;
          rise_count++;
        end
        pw_cnt = 1;
      end else if (lcd_e) begin
        pw_cnt++;
      end else if (e_prev) begin
        chk("pulse_width", pw_cnt, int'(T_PW));
      end
      e_prev = lcd_e;
    end
  end

  task automatic send(input logic rs, input logic [7:0] d, output int acc);
    item_t it;
    wr_valid = 1'b1;
    wr_rs    = rs;
    wr_data  = d;
    acc      = -1;
    for (int i = 0; i < 500; i++) begin
      if (wr_ready) begin
        acc     = cyc + 1;
        it.rs   = rs;
        it.data = d;
        it.acc  = acc;
        exp_q.push_back(it);
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    wr_valid = 1'b0;
    if (acc < 0) bound_expired("accept_timeout");
  endtask

  // Caller chooses the assertion instant; outputs must be in reset 1 time unit later.
  task automatic apply_reset();
    rst_n    = 1'b0;
    wr_valid = 1'b0;
    exp_q.delete();
    #1;
    chk("rst_lcd_e", int'(lcd_e), 0);
    chk("rst_wr_ready", int'(wr_ready), 0);
    chk("rst_busy", int'(busy), 1);
    chk("rst_lcd_data", int'({lcd_rs, lcd_data}), 0);
    repeat (3) @(negedge clk);
    rst_n      = 1'b1;
    rel_cyc    = cyc;
    ready_edge = cyc + int'(T_POWERUP) + 1;
  endtask

  task automatic wait_cyc(input int target);
    for (int i = 0; i < 5000 && cyc < target; i++) @(negedge clk);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 3000; i++) begin
      if (exp_q.size() == 0 && !busy) return;
      @(negedge clk);
    end
    bound_expired("drain");
  endtask

  int acc;
  int accs[6];
  int rc0;
  int idle_start;
  int early;
  logic [7:0] b;

  initial begin
    repeat (2) @(negedge clk);

    // Reset / power-up, single short write, busy release after execution.
    @(negedge clk);
    apply_reset();
    send(1'b0, 8'h38, acc);
    rc0 = rise_count;
    for (int i = 0; i < 200 && rise_count == rc0; i++) @(negedge clk);
    if (rise_count == rc0) bound_expired("first_rise");
    idle_start = last_rise + int'(T_PW) + int'(T_HOLD) + int'(T_EXEC);
    wait_cyc(idle_start - 1);
    chk("busy_before_idle", int'(busy), 1);
    @(negedge clk);
    chk("busy_at_idle", int'(busy), 0);
    wait_drain();

    // Long execution after clear, then a data write.
    send(1'b0, 8'h01, acc);
    send(1'b1, 8'h50, acc);
    wait_drain();

    // 0x00 and 0x04 are normal instructions; 0x02/0x03 are long.
    send(1'b0, 8'h00, acc);
    send(1'b0, 8'h04, acc);
    send(1'b0, 8'h02, acc);
    send(1'b0, 8'h03, acc);
    wait_drain();

    // Random backpressure.
    for (int n = 0; n < 20; n++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      b = 8'($urandom_range(0, 255));
      send(1'($urandom_range(0, 1)), b, acc);
    end
    wait_drain();

    // Full FIFO during power-up, pointer wrap.
    @(negedge clk);
    apply_reset();
    for (int n = 0; n < 6; n++) begin
      b = 8'h41 + 8'(n);
      send(1'b1, b, accs[n]);
    end
    early = 0;
    for (int n = 0; n < 6; n++) if (accs[n] >= 0 && accs[n] <= rel_cyc + int'(T_POWERUP) + 1) early++;
    chk("accepted_before_pop", early, 4);
    chk("fifth_accept_edge", accs[4], rel_cyc + int'(T_POWERUP) + 2);
    wait_drain();

    // Reset in the middle of a pulse discards the FIFO and restarts power-up.
    send(1'b0, 8'h72, acc);
    send(1'b1, 8'h11, acc);
    send(1'b1, 8'h22, acc);
    for (int i = 0; i < 200 && !lcd_e; i++) @(negedge clk);
    if (!lcd_e) bound_expired("pulse_for_reset");
    #2;
    apply_reset();
    wait_cyc(rel_cyc + int'(T_POWERUP) - 1);
    chk("busy_in_powerup", int'(busy), 1);
    @(negedge clk);
    chk("busy_after_discard", int'(busy), 0);
    send(1'b1, 8'h33, acc);
    wait_drain();

    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
